// File: rtl/store_cmd_issuer_if.sv
// Core command/result ports and the store stage's A/B/Z strobe-ack channels.
// master = issuer side, slave = core plus store stage.
interface store_cmd_issuer_if;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] output_a;
    logic        output_a_stb;
    logic        output_a_ack;
    logic [31:0] output_b;
    logic        output_b_stb;
    logic        output_b_ack;
    logic [31:0] input_z;
    logic        input_z_stb;
    logic        input_z_ack;

    modport master (
        input  cmd_addr, cmd_data, cmd_valid,
        output cmd_ready,
        output res_data, res_valid,
        input  res_ready,
        output output_a, output_a_stb,
        input  output_a_ack,
        output output_b, output_b_stb,
        input  output_b_ack,
        input  input_z, input_z_stb,
        output input_z_ack
    );

    modport slave (
        output cmd_addr, cmd_data, cmd_valid,
        input  cmd_ready,
        input  res_data, res_valid,
        output res_ready,
        input  output_a, output_a_stb,
        output output_a_ack,
        input  output_b, output_b_stb,
        output output_b_ack,
        output input_z, input_z_stb,
        input  input_z_ack
    );
endinterface

// File: rtl/store_cmd_issuer.sv
// Queues (addr, data) store commands and replays them one at a time to the store
// stage as operands A/B, returning the stage's Z word on the result port.
module store_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    store_cmd_issuer_if.master bus,
    output logic               busy,
    output logic [CNT_W-1:0]   done_count
);
    localparam int             PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, GET_Z, PUT_RES} state_t;

    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    state_t           state_q;
    logic [31:0]      data_q, a_q, b_q, res_q;
    logic             a_stb_q, b_stb_q, z_ack_q, res_vld_q;
    logic [CNT_W-1:0] done_q;

    assign bus.cmd_ready = (count_q != FULL);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    // Popping only from IDLE keeps exactly one command in flight.
    assign pop           = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
        else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= bus.cmd_addr;
            data_mem[wr_ptr_q] <= bus.cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            a_stb_q   <= 1'b0;
            b_stb_q   <= 1'b0;
            z_ack_q   <= 1'b0;
            res_vld_q <= 1'b0;
            done_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    a_q     <= addr_mem[rd_ptr_q];
                    data_q  <= data_mem[rd_ptr_q];
                    a_stb_q <= 1'b1;
                    state_q <= SEND_A;
                end
                SEND_A: if (a_stb_q && bus.output_a_ack) begin
                    a_stb_q <= 1'b0;
                    b_q     <= data_q;
                    b_stb_q <= 1'b1;
                    state_q <= SEND_B;
                end
                SEND_B: if (b_stb_q && bus.output_b_ack) begin
                    b_stb_q <= 1'b0;
                    z_ack_q <= 1'b1;
                    state_q <= GET_Z;
                end
                GET_Z: if (z_ack_q && bus.input_z_stb) begin
                    res_q     <= bus.input_z;
                    z_ack_q   <= 1'b0;
                    res_vld_q <= 1'b1;
                    state_q   <= PUT_RES;
                end
                PUT_RES: if (res_vld_q && bus.res_ready) begin
                    res_vld_q <= 1'b0;
                    done_q    <= done_q + CNT_W'(1);
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.output_a     = a_q;
    assign bus.output_a_stb = a_stb_q;
    assign bus.output_b     = b_q;
    assign bus.output_b_stb = b_stb_q;
    assign bus.input_z_ack  = z_ack_q;
    assign bus.res_data     = res_q;
    assign bus.res_valid    = res_vld_q;
    assign done_count       = done_q;
    assign busy             = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_store_cmd_issuer.sv
// Bench for store_cmd_issuer: a behavioural store stage (RAM read-back returns the
// stored data word) and result sink with tunable delays, checked against queues.
module tb_store_cmd_issuer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] done_count;

    store_cmd_issuer_if bus ();

    store_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_a[$], exp_b[$], exp_r[$];
    logic [31:0] a_log[$], b_log[$], r_log[$];
    int exp_done = 0;
    int a_min = 0, a_max = 0, b_min = 0, b_max = 0, z_min = 0, z_max = 0, r_min = 0, r_max = 0;
    bit z_hold = 0, noise_en = 0;
    int a_viol = 0, b_viol = 0, r_viol = 0, z_spur = 0, overlap = 0;

    int a_wait, a_cur, b_wait, b_cur, z_wait, z_cur, r_wait, r_cur;
    bit a_act, b_act, z_pend, r_act, a_prev, b_prev, r_prev;
    logic [31:0] a_prev_d, b_prev_d, r_prev_d, z_val;

    // Store stage and result sink; all decisions made on the falling edge.
    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0; bus.res_ready = 1'b0;
        bus.output_a_ack = 1'b0; bus.output_b_ack = 1'b0; bus.input_z = '0; bus.input_z_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bus.output_a_ack = 1'b0; bus.output_b_ack = 1'b0;
                bus.input_z_stb = 1'b0; bus.res_ready = 1'b0;
                a_act = 0; b_act = 0; z_pend = 0; r_act = 0;
                a_prev = 0; b_prev = 0; r_prev = 0;
            end else begin
                if (z_pend) begin
                    if (!z_hold && z_wait >= z_cur) begin
                        bus.input_z_stb = 1'b1; bus.input_z = z_val;
                        if (bus.input_z_ack) z_pend = 0;
                    end else begin
                        bus.input_z_stb = 1'b0; bus.input_z = $urandom;
                        if (!z_hold) z_wait++;
                    end
                end else begin
                    bus.input_z_stb = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    bus.input_z = $urandom;
                    if (bus.input_z_stb && bus.input_z_ack) z_spur++;
                end

                if (bus.output_b_stb) begin
                    if (b_prev && bus.output_b !== b_prev_d) b_viol++;
                    if (!b_act) begin b_act = 1; b_wait = 0; b_cur = $urandom_range(b_min, b_max); end
                    bus.output_b_ack = (b_wait >= b_cur);
                    if (bus.output_b_ack) begin
                        b_log.push_back(bus.output_b);
                        b_act = 0; b_prev = 0;
                        z_pend = 1; z_val = bus.output_b; z_wait = 0; z_cur = $urandom_range(z_min, z_max);
                    end else begin
                        b_wait++; b_prev = 1; b_prev_d = bus.output_b;
                    end
                end else begin
                    if (b_prev) b_viol++;
                    bus.output_b_ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    b_prev = 0;
                end

                if (bus.output_a_stb) begin
                    if (a_prev && bus.output_a !== a_prev_d) a_viol++;
                    if (!a_act) begin a_act = 1; a_wait = 0; a_cur = $urandom_range(a_min, a_max); end
                    bus.output_a_ack = (a_wait >= a_cur);
                    if (bus.output_a_ack) begin
                        a_log.push_back(bus.output_a); a_act = 0; a_prev = 0;
                    end else begin
                        a_wait++; a_prev = 1; a_prev_d = bus.output_a;
                    end
                end else begin
                    if (a_prev) a_viol++;
                    bus.output_a_ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    a_prev = 0;
                end

                if (bus.res_valid) begin
                    if (r_prev && bus.res_data !== r_prev_d) r_viol++;
                    if (bus.output_a_stb) overlap++;
                    if (!r_act) begin r_act = 1; r_wait = 0; r_cur = $urandom_range(r_min, r_max); end
                    bus.res_ready = (r_wait >= r_cur);
                    if (bus.res_ready) begin
                        r_log.push_back(bus.res_data);
                        exp_done = (exp_done + 1) % (1 << CNT_W);
                        r_act = 0; r_prev = 0;
                    end else begin
                        r_wait++; r_prev = 1; r_prev_d = bus.res_data;
                    end
                end else begin
                    if (r_prev) r_viol++;
                    bus.res_ready = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    r_prev = 0;
                end
            end
        end
    end

    // Caller sits just after a falling edge; returns one falling edge after acceptance.
    task automatic push_cmd(input logic [31:0] a, input logic [31:0] d, output bit ok);
        int n = 0;
        ok = 0;
        bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_valid = 1'b1;
        while (1) begin
            if (bus.cmd_ready) begin
                exp_a.push_back(a); exp_b.push_back(d); exp_r.push_back(d);
                ok = 1;
            end
            @(negedge clk);
            n++;
            if (ok || n >= 3000) break;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        ok = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (r_log.size() == exp_r.size() && !busy && !bus.res_valid) begin ok = 1; break; end
        end
    endtask

    task automatic clear_logs;
        exp_a.delete(); exp_b.delete(); exp_r.delete();
        a_log.delete(); b_log.delete(); r_log.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if ({bus.output_a_stb, bus.output_b_stb, bus.input_z_ack, bus.res_valid} !== 4'b0)
            begin failures++; $display("FAIL reset_strobes: got %b want 0000", {bus.output_a_stb, bus.output_b_stb, bus.input_z_ack, bus.res_valid}); end
        checks++; if ({bus.output_a, bus.output_b, bus.res_data} !== 96'b0)
            begin failures++; $display("FAIL reset_data: got %h %h %h want zeros", bus.output_a, bus.output_b, bus.res_data); end
        checks++; if ({bus.cmd_ready, busy, done_count} !== {2'b10, {CNT_W{1'b0}}})
            begin failures++; $display("FAIL reset_status: got rdy=%b busy=%b done=%0d want 1 0 0", bus.cmd_ready, busy, done_count); end
        rst = 1'b1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        @(negedge clk);
        b_min = 100000; b_max = 100000;
        for (int i = 0; i < 4; i++) begin
            push_cmd($urandom, $urandom, ok);
            checks++; if (!ok) begin failures++; $display("FAIL reset_mid_push: got timeout want accept (cmd %0d)", i); end
        end
        n = 0;
        while (!bus.output_b_stb && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        checks++; if ({bus.output_b_stb, busy} !== 2'b11)
            begin failures++; $display("FAIL reset_mid_stall: got b_stb=%b busy=%b want 1 1", bus.output_b_stb, busy); end
        checks++; if (b_log.size() != 0) begin failures++; $display("FAIL reset_mid_nob: got %0d B transfers want 0", b_log.size()); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({bus.output_a_stb, bus.output_b_stb, bus.input_z_ack, bus.res_valid} !== 4'b0)
            begin failures++; $display("FAIL reset_mid_strobes: got %b want 0000", {bus.output_a_stb, bus.output_b_stb, bus.input_z_ack, bus.res_valid}); end
        checks++; if ({bus.cmd_ready, busy} !== 2'b10)
            begin failures++; $display("FAIL reset_mid_status: got rdy=%b busy=%b want 1 0", bus.cmd_ready, busy); end
        checks++; if (done_count !== '0) begin failures++; $display("FAIL reset_mid_done: got %0d want 0", done_count); end
        @(negedge clk);
        rst = 1'b1; b_min = 0; b_max = 0;
        clear_logs(); exp_done = 0;
        n = 0;
        repeat (10) begin @(negedge clk); if (bus.output_a_stb) n++; end
        checks++; if (n != 0 || busy !== 1'b0)
            begin failures++; $display("FAIL reset_mid_quiet: got %0d A strobe cycles busy=%b want 0 0", n, busy); end
    endtask

    task automatic test_single;
        bit ok;
        @(negedge clk);
        clear_logs();
        push_cmd(32'h0000_0010, 32'h3F80_0000, ok);
        checks++; if (bus.output_a_stb !== 1'b0) begin failures++; $display("FAIL single_idle: got a_stb=%b want 0", bus.output_a_stb); end
        @(negedge clk);
        checks++; if ({bus.output_a_stb, bus.output_a} !== {1'b1, 32'h0000_0010})
            begin failures++; $display("FAIL single_pop: got stb=%b a=%h want 1 00000010", bus.output_a_stb, bus.output_a); end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_drain: got timeout want drained"); end
        checks++; if (a_log.size() != 1 || b_log.size() != 1)
            begin failures++; $display("FAIL single_once: got A=%0d B=%0d transfers want 1 1", a_log.size(), b_log.size()); end
        if (a_log.size() == 1 && b_log.size() == 1) begin
            checks++; if ({a_log[0], b_log[0]} !== {32'h0000_0010, 32'h3F80_0000})
                begin failures++; $display("FAIL single_ops: got %h %h want 00000010 3f800000", a_log[0], b_log[0]); end
        end
        checks++; if (r_log.size() != 1 || bus.res_data !== 32'h3F80_0000)
            begin failures++; $display("FAIL single_res: got %0d results data=%h want 1 3f800000", r_log.size(), bus.res_data); end
        checks++; if (done_count !== CNT_W'(1)) begin failures++; $display("FAIL single_done: got %0d want 1", done_count); end
    endtask

    task automatic test_fifo_full;
        bit ok;
        int n, d0;
        logic [31:0] a6, d6;
        @(negedge clk);
        clear_logs();
        d0 = exp_done;
        z_hold = 1;
        for (int i = 0; i < 5; i++) begin
            push_cmd($urandom, $urandom, ok);
            checks++; if (!ok) begin failures++; $display("FAIL fifo_push: got timeout want accept (cmd %0d)", i); end
        end
        repeat (5) @(negedge clk);
        checks++; if ({bus.cmd_ready, busy} !== 2'b01)
            begin failures++; $display("FAIL fifo_full: got rdy=%b busy=%b want 0 1", bus.cmd_ready, busy); end
        checks++; if (a_log.size() != 1 || r_log.size() != 0)
            begin failures++; $display("FAIL fifo_inflight: got A=%0d R=%0d want 1 0", a_log.size(), r_log.size()); end
        a6 = $urandom; d6 = $urandom;
        bus.cmd_addr = a6; bus.cmd_data = d6; bus.cmd_valid = 1'b1;
        n = 0;
        repeat (8) begin @(negedge clk); if (bus.cmd_ready) n++; end
        checks++; if (n != 0) begin failures++; $display("FAIL fifo_held: got %0d ready cycles want 0", n); end
        z_hold = 0;
        push_cmd(a6, d6, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fifo_sixth: got timeout want accept"); end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL fifo_drain: got timeout want drained"); end
        n = 0;
        for (int i = 0; i < exp_r.size(); i++) if (i >= r_log.size() || r_log[i] !== exp_r[i]) n++;
        checks++; if (r_log.size() != 6 || n != 0)
            begin failures++; $display("FAIL fifo_order: got %0d results %0d misordered want 6 0", r_log.size(), n); end
        checks++; if (done_count !== CNT_W'((d0 + 6) % (1 << CNT_W)))
            begin failures++; $display("FAIL fifo_done: got %0d want %0d", done_count, (d0 + 6) % (1 << CNT_W)); end
    endtask

    task automatic test_res_hold;
        bit ok;
        int n;
        @(negedge clk);
        clear_logs();
        r_min = 10; r_max = 10;
        push_cmd($urandom, $urandom, ok);
        push_cmd($urandom, $urandom, ok);
        n = 0;
        while (!bus.res_valid && n < 100) begin @(negedge clk); n++; end
        for (int k = 0; k < 10; k++) begin
            checks++; if ({bus.res_valid, bus.output_a_stb, bus.res_data} !== {2'b10, exp_r[0]})
                begin failures++; $display("FAIL res_hold_c%0d: got vld=%b a_stb=%b d=%h want 1 0 %h", k, bus.res_valid, bus.output_a_stb, bus.res_data, exp_r[0]); end
            @(negedge clk);
        end
        r_min = 0; r_max = 0;
        wait_drain(ok);
        checks++; if (!ok || r_log.size() != 2 || r_log[0] !== exp_r[0] || r_log[1] !== exp_r[1])
            begin failures++; $display("FAIL res_hold_order: got %0d results want 2 in push order", r_log.size()); end
        checks++; if (overlap != 0 || r_viol != 0)
            begin failures++; $display("FAIL res_hold_proto: got overlap=%0d unstable=%0d want 0 0", overlap, r_viol); end
    endtask

    task automatic test_a_delay;
        bit ok;
        int n;
        logic [31:0] addr;
        @(negedge clk);
        clear_logs();
        a_min = 7; a_max = 7;
        addr = $urandom;
        push_cmd(addr, $urandom, ok);
        n = 0;
        while (!bus.output_a_stb && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 8; k++) begin
            checks++; if ({bus.output_a_stb, bus.output_b_stb, bus.output_a} !== {2'b10, addr})
                begin failures++; $display("FAIL a_delay_c%0d: got a_stb=%b b_stb=%b a=%h want 1 0 %h", k, bus.output_a_stb, bus.output_b_stb, bus.output_a, addr); end
            @(negedge clk);
        end
        checks++; if ({bus.output_a_stb, bus.output_b_stb} !== 2'b01)
            begin failures++; $display("FAIL a_delay_b_rise: got a_stb=%b b_stb=%b want 0 1", bus.output_a_stb, bus.output_b_stb); end
        a_min = 0; a_max = 0;
        wait_drain(ok);
        checks++; if (!ok || a_log.size() != 1 || a_viol != 0)
            begin failures++; $display("FAIL a_delay_xfer: got %0d A transfers %0d unstable want 1 0", a_log.size(), a_viol); end
    endtask

    task automatic test_random;
        bit ok;
        int na, nb, nr;
        @(negedge clk);
        clear_logs();
        a_max = 3; b_max = 3; z_max = 4; r_max = 3; noise_en = 1;
        for (int i = 0; i < 24; i++) begin
            push_cmd($urandom, $urandom, ok);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain(ok);
        noise_en = 0; a_max = 0; b_max = 0; z_max = 0; r_max = 0;
        checks++; if (!ok) begin failures++; $display("FAIL random_drain: got timeout want drained"); end
        na = 0; nb = 0; nr = 0;
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i >= a_log.size() || a_log[i] !== exp_a[i]) na++;
            if (i >= b_log.size() || b_log[i] !== exp_b[i]) nb++;
            if (i >= r_log.size() || r_log[i] !== exp_r[i]) nr++;
        end
        checks++; if (a_log.size() != exp_a.size() || na != 0)
            begin failures++; $display("FAIL random_a: got %0d entries %0d wrong want %0d 0", a_log.size(), na, exp_a.size()); end
        checks++; if (b_log.size() != exp_b.size() || nb != 0)
            begin failures++; $display("FAIL random_b: got %0d entries %0d wrong want %0d 0", b_log.size(), nb, exp_b.size()); end
        checks++; if (r_log.size() != exp_r.size() || nr != 0)
            begin failures++; $display("FAIL random_res: got %0d entries %0d wrong want %0d 0", r_log.size(), nr, exp_r.size()); end
        checks++; if (done_count !== CNT_W'(exp_done))
            begin failures++; $display("FAIL random_done: got %0d want %0d", done_count, exp_done); end
        checks++; if (a_viol + b_viol + r_viol + z_spur + overlap != 0)
            begin failures++; $display("FAIL random_proto: got a=%0d b=%0d r=%0d zspur=%0d ovl=%0d want all 0", a_viol, b_viol, r_viol, z_spur, overlap); end
    endtask

    task automatic test_wrap;
        bit ok;
        int n = 0;
        @(negedge clk);
        while (exp_done != (1 << CNT_W) - 1 && n < 40) begin
            clear_logs();
            push_cmd($urandom, $urandom, ok);
            wait_drain(ok);
            n++;
        end
        checks++; if (done_count !== {CNT_W{1'b1}})
            begin failures++; $display("FAIL wrap_max: got %0d want %0d", done_count, (1 << CNT_W) - 1); end
        clear_logs();
        push_cmd($urandom, $urandom, ok);
        wait_drain(ok);
        checks++; if (done_count !== '0) begin failures++; $display("FAIL wrap_zero: got %0d want 0", done_count); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_fifo_full();
        test_res_hold();
        test_a_delay();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
